// File: rtl/slave_port.sv
// Serial-bus slave responder: takes a bit-serial address/burst header, then
// writes deserialised words into local memory or streams memory words back out.
module slave_port #(
    parameter int ADDR_LEN  = 12,
    parameter int DATA_LEN  = 8,
    parameter int BURST_LEN = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                master_valid,
    input  logic                master_ready,
    input  logic                write_en,
    input  logic                read_en,
    input  logic                rx_address,
    input  logic                rx_burst_number,
    input  logic                rx_data,
    output logic                slave_ready,
    output logic                slave_valid,
    output logic                tx_data,
    output logic                tx_done,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic [DATA_LEN-1:0] mem_wdata,
    output logic                mem_we,
    output logic                mem_re,
    input  logic [DATA_LEN-1:0] mem_rdata
);

    localparam int MAX_AB  = (ADDR_LEN > BURST_LEN) ? ADDR_LEN : BURST_LEN;
    localparam int MAX_LEN = (MAX_AB > DATA_LEN) ? MAX_AB : DATA_LEN;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_BURST, S_WDATA, S_WMEM,
        S_RFETCH, S_RWAIT, S_RDATA, S_DONE
    } state_t;

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     bit_cnt_reg, bit_cnt_next;
    logic [ADDR_LEN-1:0]  addr_reg, addr_next;
    logic [BURST_LEN-1:0] burst_reg, burst_next;
    logic [BURST_LEN-1:0] last_idx_reg, last_idx_next;
    logic [BURST_LEN-1:0] word_cnt_reg, word_cnt_next;
    logic [DATA_LEN-1:0]  shift_reg, shift_next;
    logic                 is_write_reg, is_write_next;

    logic                 slave_ready_reg, slave_ready_next;
    logic                 slave_valid_reg, slave_valid_next;
    logic                 tx_data_reg, tx_data_next;
    logic                 tx_done_reg, tx_done_next;
    logic [ADDR_LEN-1:0]  mem_addr_reg, mem_addr_next;
    logic [DATA_LEN-1:0]  mem_wdata_reg, mem_wdata_next;
    logic                 mem_we_reg, mem_we_next;
    logic                 mem_re_reg, mem_re_next;

    logic                 enables_lost;
    logic [BURST_LEN-1:0] burst_value;
    logic                 last_word;

    // Losing the latched direction's enable (both low, or a swap) aborts.
    assign enables_lost = is_write_reg ? !write_en : !read_en;
    assign burst_value  = {rx_burst_number, burst_reg[BURST_LEN-1:1]};
    assign last_word    = (word_cnt_reg == last_idx_reg);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg       <= S_IDLE;
            bit_cnt_reg     <= '0;
            addr_reg        <= '0;
            burst_reg       <= '0;
            last_idx_reg    <= '0;
            word_cnt_reg    <= '0;
            shift_reg       <= '0;
            is_write_reg    <= 1'b0;
            slave_ready_reg <= 1'b1;
            slave_valid_reg <= 1'b0;
            tx_data_reg     <= 1'b0;
            tx_done_reg     <= 1'b0;
            mem_addr_reg    <= '0;
            mem_wdata_reg   <= '0;
            mem_we_reg      <= 1'b0;
            mem_re_reg      <= 1'b0;
        end else begin
            state_reg       <= state_next;
            bit_cnt_reg     <= bit_cnt_next;
            addr_reg        <= addr_next;
            burst_reg       <= burst_next;
            last_idx_reg    <= last_idx_next;
            word_cnt_reg    <= word_cnt_next;
            shift_reg       <= shift_next;
            is_write_reg    <= is_write_next;
            slave_ready_reg <= slave_ready_next;
            slave_valid_reg <= slave_valid_next;
            tx_data_reg     <= tx_data_next;
            tx_done_reg     <= tx_done_next;
            mem_addr_reg    <= mem_addr_next;
            mem_wdata_reg   <= mem_wdata_next;
            mem_we_reg      <= mem_we_next;
            mem_re_reg      <= mem_re_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        bit_cnt_next  = bit_cnt_reg;
        addr_next     = addr_reg;
        burst_next    = burst_reg;
        last_idx_next = last_idx_reg;
        word_cnt_next = word_cnt_reg;
        shift_next    = shift_reg;
        is_write_next = is_write_reg;
        case (state_reg)
            S_IDLE: begin
                if (master_valid && (write_en ^ read_en)) begin
                    state_next    = S_ADDR;
                    is_write_next = write_en;
                    addr_next     = {rx_address, addr_reg[ADDR_LEN-1:1]};
                    bit_cnt_next  = CNT_W'(1);
                    word_cnt_next = '0;
                end
            end
            S_ADDR: begin
                if (master_valid) begin
                    addr_next = {rx_address, addr_reg[ADDR_LEN-1:1]};
                    if (bit_cnt_reg == CNT_W'(ADDR_LEN - 1)) begin
                        state_next   = S_BURST;
                        bit_cnt_next = '0;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + CNT_W'(1);
                    end
                end
            end
            S_BURST: begin
                if (master_valid) begin
                    burst_next = burst_value;
                    if (bit_cnt_reg == CNT_W'(BURST_LEN - 1)) begin
                        // A zero burst count still moves one word.
                        last_idx_next = (burst_value == '0) ? '0 : burst_value - BURST_LEN'(1);
                        state_next    = is_write_reg ? S_WDATA : S_RFETCH;
                        bit_cnt_next  = '0;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + CNT_W'(1);
                    end
                end
            end
            S_WDATA: begin
                if (master_valid) begin
                    shift_next = {rx_data, shift_reg[DATA_LEN-1:1]};
                    if (bit_cnt_reg == CNT_W'(DATA_LEN - 1)) begin
                        state_next   = S_WMEM;
                        bit_cnt_next = '0;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + CNT_W'(1);
                    end
                end
            end
            S_WMEM: begin
                if (last_word) begin
                    state_next = S_DONE;
                end else begin
                    state_next    = S_WDATA;
                    word_cnt_next = word_cnt_reg + BURST_LEN'(1);
                end
            end
            S_RFETCH: state_next = S_RWAIT;
            S_RWAIT: begin
                shift_next   = mem_rdata;
                bit_cnt_next = '0;
                state_next   = S_RDATA;
            end
            S_RDATA: begin
                if (master_ready && slave_valid_reg) begin
                    shift_next = shift_reg >> 1;
                    if (bit_cnt_reg == CNT_W'(DATA_LEN - 1)) begin
                        bit_cnt_next = '0;
                        if (last_word) begin
                            state_next = S_DONE;
                        end else begin
                            state_next    = S_RFETCH;
                            word_cnt_next = word_cnt_reg + BURST_LEN'(1);
                        end
                    end else begin
                        bit_cnt_next = bit_cnt_reg + CNT_W'(1);
                    end
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (state_reg != S_IDLE && state_reg != S_DONE && enables_lost) begin
            state_next = S_IDLE;
        end
    end

    // Outputs are decoded from the next state so every strobe is a flop output.
    always_comb begin
        slave_ready_next = (state_next == S_IDLE);
        slave_valid_next = (state_next == S_RDATA);
        tx_data_next     = (state_next == S_RDATA) ? shift_next[0] : 1'b0;
        tx_done_next     = (state_next == S_DONE);
        mem_we_next      = (state_next == S_WMEM);
        mem_re_next      = (state_next == S_RFETCH);
        mem_addr_next    = mem_addr_reg;
        mem_wdata_next   = mem_wdata_reg;
        if (mem_we_next || mem_re_next) begin
            mem_addr_next = addr_reg + ADDR_LEN'(word_cnt_next);
        end
        if (mem_we_next) begin
            mem_wdata_next = shift_next;
        end
    end

    assign slave_ready = slave_ready_reg;
    assign slave_valid = slave_valid_reg;
    assign tx_data     = tx_data_reg;
    assign tx_done     = tx_done_reg;
    assign mem_addr    = mem_addr_reg;
    assign mem_wdata   = mem_wdata_reg;
    assign mem_we      = mem_we_reg;
    assign mem_re      = mem_re_reg;

endmodule

// File: tb/tb_slave_port.sv
// Directed bench for slave_port: scoreboard queues for memory writes, read
// fetches and serial read bits, with a registered-read memory model.
module tb_slave_port;

    logic        clk = 1'b0;
    logic        reset, master_valid, master_ready, write_en, read_en;
    logic        rx_address, rx_burst_number, rx_data;
    logic        slave_ready, slave_valid, tx_data, tx_done, mem_we, mem_re;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;

    logic [7:0]  mem_model [0:4095];
    logic [19:0] wq[$];
    logic [11:0] req_q[$];
    logic        rq[$];
    int          passed = 0, failed = 0, total = 0;
    int          done_cnt = 0, exp_done = 0;

    slave_port dut (
        .clk(clk), .reset(reset), .master_valid(master_valid), .master_ready(master_ready),
        .write_en(write_en), .read_en(read_en), .rx_address(rx_address),
        .rx_burst_number(rx_burst_number), .rx_data(rx_data), .slave_ready(slave_ready),
        .slave_valid(slave_valid), .tx_data(tx_data), .tx_done(tx_done), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_re) mem_rdata <= mem_model[mem_addr];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (wq.size() == 0) check("we_unexpected", 32'(mem_we), 32'd0);
            else check("we_addr_data", 32'({mem_addr, mem_wdata}), 32'(wq.pop_front()));
        end
        if (mem_re === 1'b1) begin
            if (req_q.size() == 0) check("re_unexpected", 32'(mem_re), 32'd0);
            else check("re_addr", 32'(mem_addr), 32'(req_q.pop_front()));
        end
        if (tx_done === 1'b1) done_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_header(input logic [11:0] addr, input logic [11:0] burst);
        for (int i = 0; i < 12; i++) begin
            master_valid = 1'b1; rx_address = addr[i]; step();
        end
        for (int i = 0; i < 12; i++) begin
            master_valid = 1'b1; rx_burst_number = burst[i]; step();
        end
        master_valid = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] d, input int stall_at, input int stall_len);
        for (int i = 0; i < 8; i++) begin
            if (i == stall_at) begin
                master_valid = 1'b0;
                repeat (stall_len) step();
            end
            master_valid = 1'b1; rx_data = d[i]; step();
        end
        master_valid = 1'b0;
    endtask

    // Entered with the DUT in RDATA; consumes the 8 expected bits in rq.
    task automatic recv_word(input int stall_at, input int stall_len);
        int bits = 0, stalled = 0, t = 0;
        while (bits < 8 && t < 64) begin
            t++;
            if (bits == stall_at && stalled < stall_len) begin
                master_ready = 1'b0;
                stalled++;
                check("hold_valid", 32'(slave_valid), 32'd1);
                check("hold_bit", 32'(tx_data), 32'(rq[0]));
            end else if (slave_valid === 1'b1) begin
                master_ready = 1'b1;
                check("tx_bit", 32'(tx_data), 32'(rq.pop_front()));
                bits++;
            end else begin
                master_ready = 1'b1;
            end
            step();
        end
        check("read_bits_done", 32'(bits), 32'd8);
    endtask

    task automatic do_read(input logic [11:0] addr, input int stall_at, input int stall_len);
        for (int i = 0; i < 8; i++) rq.push_back(mem_model[addr][i]);
        req_q.push_back(addr);
        read_en = 1'b1; master_ready = 1'b0;
        send_header(addr, 12'd1);
        check("rfetch_re", 32'(mem_re), 32'd1);
        check("rfetch_addr", 32'(mem_addr), 32'(addr));
        step();
        check("rwait_valid", 32'(slave_valid), 32'd0);
        step();
        check("rdata_valid", 32'(slave_valid), 32'd1);
        recv_word(stall_at, stall_len);
        exp_done++;
        check("read_tx_done", 32'(tx_done), 32'd1);
        check("read_valid_drop", 32'(slave_valid), 32'd0);
        read_en = 1'b0;
        step();
        check("read_ready_after", 32'(slave_ready), 32'd1);
        check("read_done_cnt", 32'(done_cnt), 32'(exp_done));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem_model[i] = 8'(i * 37 + 5);
        mem_model[12'h010] = 8'h96;
        mem_model[12'h123] = 8'h5A;
        mem_model[12'h020] = 8'hA7;
        mem_rdata = 8'h00;
        reset = 1'b0; master_valid = 1'b0; master_ready = 1'b0;
        write_en = 1'b0; read_en = 1'b0;
        rx_address = 1'b0; rx_burst_number = 1'b0; rx_data = 1'b0;

        // Reset state
        repeat (3) step();
        check("rst_ready", 32'(slave_ready), 32'd1);
        check("rst_valid", 32'(slave_valid), 32'd0);
        check("rst_tx_done", 32'(tx_done), 32'd0);
        check("rst_we_re", 32'({mem_we, mem_re, tx_data}), 32'd0);
        reset = 1'b1;
        step();
        check("idle_ready", 32'(slave_ready), 32'd1);

        // Single write
        write_en = 1'b1;
        wq.push_back({12'h0A5, 8'h3C});
        send_header(12'h0A5, 12'd1);
        check("wr1_ready_low", 32'(slave_ready), 32'd0);
        send_word(8'h3C, -1, 0);
        check("wr1_we", 32'(mem_we), 32'd1);
        check("wr1_addr", 32'(mem_addr), 32'h0A5);
        check("wr1_wdata", 32'(mem_wdata), 32'h3C);
        step();
        exp_done++;
        check("wr1_tx_done", 32'(tx_done), 32'd1);
        check("wr1_we_drop", 32'(mem_we), 32'd0);
        write_en = 1'b0;
        step();
        check("wr1_ready_after", 32'(slave_ready), 32'd1);
        check("wr1_done_pulse", 32'(tx_done), 32'd0);

        // Burst write with address wrap and a mid-word stall
        write_en = 1'b1;
        wq.push_back({12'hFFE, 8'h11});
        wq.push_back({12'hFFF, 8'h22});
        wq.push_back({12'h000, 8'h33});
        send_header(12'hFFE, 12'd3);
        send_word(8'h11, -1, 0);
        step();
        send_word(8'h22, 4, 2);
        step();
        send_word(8'h33, -1, 0);
        check("wr3_last_addr", 32'(mem_addr), 32'h000);
        step();
        exp_done++;
        check("wr3_tx_done", 32'(tx_done), 32'd1);
        write_en = 1'b0;
        step();
        check("wr3_queue_empty", 32'(wq.size()), 32'd0);
        check("wr3_done_cnt", 32'(done_cnt), 32'(exp_done));

        // Reads: plain, then with a 3-cycle master_ready stall on bit 4
        do_read(12'h010, -1, 0);
        do_read(12'h123, 4, 3);

        // Both enables high: must stay idle
        write_en = 1'b1; read_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            master_valid = 1'b1; rx_address = 1'b1; step();
            check("both_en_idle", 32'(slave_ready), 32'd1);
        end
        master_valid = 1'b0; write_en = 1'b0; read_en = 1'b0;
        step();

        // Abort during RDATA
        req_q.push_back(12'h020);
        read_en = 1'b1; master_ready = 1'b1;
        send_header(12'h020, 12'd1);
        step(); step();
        check("abort_in_rdata", 32'(slave_valid), 32'd1);
        repeat (3) step();
        read_en = 1'b0;
        step();
        check("abort_ready", 32'(slave_ready), 32'd1);
        check("abort_valid", 32'(slave_valid), 32'd0);
        check("abort_no_done", 32'(tx_done), 32'd0);
        step(); step();
        check("abort_done_cnt", 32'(done_cnt), 32'(exp_done));

        // Reset mid-write
        write_en = 1'b1;
        send_header(12'h055, 12'd1);
        for (int i = 0; i < 3; i++) begin
            master_valid = 1'b1; rx_data = 1'b1; step();
        end
        check("midrst_busy", 32'(slave_ready), 32'd0);
        reset = 1'b0; master_valid = 1'b0;
        step();
        check("midrst_ready", 32'(slave_ready), 32'd1);
        check("midrst_addr", 32'(mem_addr), 32'd0);
        check("midrst_wdata", 32'(mem_wdata), 32'd0);
        check("midrst_strobes", 32'({mem_we, mem_re, tx_done, slave_valid, tx_data}), 32'd0);
        reset = 1'b1; write_en = 1'b0;
        repeat (3) step();
        check("midrst_ready_after", 32'(slave_ready), 32'd1);
        check("final_wq_empty", 32'(wq.size()), 32'd0);
        check("final_req_empty", 32'(req_q.size()), 32'd0);
        check("final_done_cnt", 32'(done_cnt), 32'(exp_done));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
